key_expand: RTL and testbench

//  AES-128 key schedule feeding the round datapath. Takes a 128-bit cipher key and computes one round key per clock.

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/bSbox.sv | 22 ++
 rtl/key_subword.sv | 15 +
 rtl/key_expand.sv | 103 ++++++++++
 tb/tb_key_expand.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, key-schedule state type and GF(2^8) helpers
package aes_pkg;

  localparam int         KW        = 128;
  localparam int         NR        = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} kx_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

endpackage

// File: rtl/bSbox.sv
// rtl/bSbox.sv - AES S-box, forward when ed=0, inverse when ed=1
module bSbox
  import aes_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic       ed,
  output logic [7:0] o_q
);

  logic [7:0] w_in;
  logic [7:0] w_inv;

  // Inverse direction undoes the affine map before inversion; forward applies it after.
  always_comb begin
    w_in  = ed ? (rotl8(i_a, 1) ^ rotl8(i_a, 3) ^ rotl8(i_a, 6) ^ 8'h05) : i_a;
    w_inv = gf_inv(w_in);
    o_q   = ed ? w_inv
               : (w_inv ^ rotl8(w_inv, 1) ^ rotl8(w_inv, 2) ^ rotl8(w_inv, 3) ^
                  rotl8(w_inv, 4) ^ 8'h63);
  end

endmodule

// File: rtl/key_subword.sv
// rtl/key_subword.sv - stateless 32-bit SubWord from four forward S-boxes
module key_subword (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    bSbox u_sbox (
      .i_a (i_word[8*g +: 8]),
      .ed  (1'b0),
      .o_q (o_word[8*g +: 8])
    );
  end

endmodule

// File: rtl/key_expand.sv
// rtl/key_expand.sv - AES-128 key schedule, one round key per clock into an 11-entry store
// Optional KEYEXP_ZEROIZE_EN: clear store[1..NR] on load and blank rKey until kReady.
module key_expand
  import aes_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          kLoad,
  input  logic [KW-1:0] cKey,
  input  logic [3:0]    rcRound,
  output logic [KW-1:0] rKey,
  output logic          kBusy,
  output logic          kReady
);

  kx_state_e     r_state;
  logic [3:0]    r_cnt;
  logic [7:0]    r_rcon;
  logic [KW-1:0] r_prev;
  logic [KW-1:0] r_store [0:NR];
  logic          r_busy;
  logic          r_ready;

  logic [31:0]   w_rot, w_sub, w_t;
  logic [31:0]   w_w0, w_w1, w_w2, w_w3;
  logic [KW-1:0] w_next;
  logic [KW-1:0] w_rd;

  assign w_rot = {r_prev[23:0], r_prev[31:24]};

  key_subword u_subword (
    .i_word (w_rot),
    .o_word (w_sub)
  );

  assign w_t    = w_sub ^ {r_rcon, 24'h0};
  assign w_w0   = r_prev[127:96] ^ w_t;
  assign w_w1   = r_prev[95:64]  ^ w_w0;
  assign w_w2   = r_prev[63:32]  ^ w_w1;
  assign w_w3   = r_prev[31:0]   ^ w_w2;
  assign w_next = {w_w0, w_w1, w_w2, w_w3};

  // kLoad wins in every state so a held strobe keeps restarting from the newest key.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rcon  <= RCON_INIT;
      r_prev  <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      for (int i = 0; i <= NR; i++) r_store[i] <= '0;
    end else if (kLoad) begin
      r_state    <= EXPAND;
      r_store[0] <= cKey;
      r_prev     <= cKey;
      r_cnt      <= 4'd1;
      r_rcon     <= RCON_INIT;
      r_busy     <= 1'b1;
      r_ready    <= 1'b0;
`ifdef KEYEXP_ZEROIZE_EN
      for (int i = 1; i <= NR; i++) r_store[i] <= '0;
`endif
    end else begin
      case (r_state)
        EXPAND: begin
          for (int i = 1; i <= NR; i++) begin
            if (r_cnt == 4'(i)) r_store[i] <= w_next;
          end
          r_prev <= w_next;
          r_rcon <= xtime(r_rcon);
          r_cnt  <= r_cnt + 4'd1;
          if (r_cnt == 4'(NR)) begin
            r_state <= READY;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  // Indices past NR fall through to zero.
  always_comb begin
    w_rd = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rcRound == 4'(i)) w_rd = r_store[i];
    end
  end

`ifdef KEYEXP_ZEROIZE_EN
  assign rKey = r_ready ? w_rd : '0;
`else
  assign rKey = w_rd;
`endif

  assign kBusy  = r_busy;
  assign kReady = r_ready;

endmodule

// File: tb/tb_key_expand.sv
// tb/tb_key_expand.sv - scoreboard bench for key_expand against a FIPS-197 word-level model
module tb_key_expand;

  logic         CLK, RST, kLoad;
  logic [127:0] cKey, rKey;
  logic [3:0]   rcRound;
  logic         kBusy, kReady;

  key_expand dut (
    .CLK(CLK), .RST(RST), .kLoad(kLoad), .cKey(cKey),
    .rcRound(rcRound), .rKey(rKey), .kBusy(kBusy), .kReady(kReady)
  );

  typedef struct {
    int           kind;
    logic [127:0] want;
    string        name;
  } chk_t;

  chk_t         q[$];
  int           total = 0;
  int           bad = 0;
  logic [7:0]   sbox [0:255];
  logic [7:0]   rcon_t [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] mk [0:10];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box table from the generator-walk construction (3 generates GF(2^8)*).
  function automatic void build_sbox();
    logic [7:0] p, g, x;
    p = 8'h01;
    g = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      g = g ^ {g[6:0], 1'b0};
      g = g ^ {g[5:0], 2'b0};
      g = g ^ {g[3:0], 4'b0};
      if (g[7]) g = g ^ 8'h09;
      x = g ^ rl(g, 1) ^ rl(g, 2) ^ rl(g, 3) ^ rl(g, 4);
      sbox[p] = x ^ 8'h63;
    end
    sbox[0] = 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic void model_load(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/4-1], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] exp_key(input logic [3:0] idx);
    return (idx <= 4'd10) ? mk[idx] : 128'h0;
  endfunction

  function automatic void sb_push(input int kind, input logic [127:0] want, input string name);
    chk_t c;
    c.kind = kind;
    c.want = want;
    c.name = name;
    q.push_back(c);
  endfunction

  initial begin : monitor
    chk_t         c;
    logic [127:0] act;
    forever begin
      @(negedge CLK);
      while (q.size() > 0) begin
        c = q.pop_front();
        case (c.kind)
          0:       act = rKey;
          1:       act = {127'b0, kBusy};
          default: act = {127'b0, kReady};
        endcase
        total++;
        if (act !== c.want) begin
          bad++;
          $display("FAIL %s: got %h want %h (rcRound=%0d t=%0t)", c.name, act, c.want, rcRound, $time);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [127:0] k);
    cKey  = k;
    kLoad = 1'b1;
    step();
    kLoad = 1'b0;
    model_load(k);
  endtask

  // Busy/ready timing after a load edge, plus what entry 0 shows mid-expansion.
  task automatic expand_check();
    rcRound = 4'd0;
    for (int n = 0; n < 10; n++) begin
      sb_push(1, 1, "busy_during_expand");
      sb_push(2, 0, "ready_during_expand");
`ifdef KEYEXP_ZEROIZE_EN
      sb_push(0, 128'h0, "rkey_zeroized_busy");
`else
      sb_push(0, mk[0], "rkey_entry0_busy");
`endif
      step();
    end
    sb_push(2, 1, "ready_rise");
    sb_push(1, 0, "busy_fall");
  endtask

  task automatic check_all(input string nm);
    for (int i = 0; i <= 10; i++) begin
      rcRound = 4'(i);
      sb_push(0, mk[i], nm);
      step();
    end
  endtask

  task automatic rand_reads(input int n);
    logic [3:0] idx;
    for (int i = 0; i < n; i++) begin
      idx = 4'($urandom_range(0, 15));
      rcRound = idx;
      sb_push(0, exp_key(idx), "rand_read");
      step();
    end
  endtask

  initial begin : stim
    logic [127:0] ka, kb;
    build_sbox();
    RST = 1'b1; kLoad = 1'b0; cKey = '0; rcRound = 4'd0;
    step();
    sb_push(1, 0, "reset_busy");
    sb_push(2, 0, "reset_ready");
    sb_push(0, 128'h0, "reset_rkey0");
    step();
    rcRound = 4'd10;
    sb_push(0, 128'h0, "reset_rkey10");
    step();
    RST = 1'b0;
    step(); step();
    sb_push(1, 0, "idle_busy");
    sb_push(2, 0, "idle_ready");
    step();

    load(128'h2b7e151628aed2a6abf7158809cf4f3c);
    expand_check();
    rcRound = 4'd1;
    sb_push(0, 128'ha0fafe1788542cb123a339392a6c7605, "fips_rk1");
    step();
    rcRound = 4'd10;
    sb_push(0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10");
    step();
    for (int i = 10; i >= 0; i--) begin
      rcRound = 4'(i);
      sb_push(0, mk[i], "decrypt_sweep");
      if (i == 0) sb_push(0, 128'h2b7e151628aed2a6abf7158809cf4f3c, "sweep_r0_ckey");
      step();
    end
    for (int i = 11; i <= 15; i++) begin
      rcRound = 4'(i);
      sb_push(0, 128'h0, "out_of_range");
      step();
    end

    load(128'h0);
    expand_check();
    rcRound = 4'd1;
    sb_push(0, 128'h62636363626363636263636362636363, "zero_rk1");
    step();
    rcRound = 4'd10;
    sb_push(0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_rk10");
    step();

    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    load(ka);
    step(); step(); step(); step();
    load(kb);
    expand_check();
    check_all("restart_keyB");

    cKey = {$urandom, $urandom, $urandom, $urandom};
    kLoad = 1'b1;
    step();
    sb_push(1, 1, "held_busy");
    sb_push(2, 0, "held_ready");
    cKey = {$urandom, $urandom, $urandom, $urandom};
    step();
    sb_push(1, 1, "held_busy");
    sb_push(2, 0, "held_ready");
    ka = {$urandom, $urandom, $urandom, $urandom};
    cKey = ka;
    step();
    kLoad = 1'b0;
    model_load(ka);
    expand_check();
    check_all("held_last_key");

    load({$urandom, $urandom, $urandom, $urandom});
    step(); step();
    rcRound = 4'd0;
    RST = 1'b1;
    sb_push(1, 0, "rst_async_busy");
    sb_push(2, 0, "rst_async_ready");
    sb_push(0, 128'h0, "rst_async_rkey");
    step();
    RST = 1'b0;
    step();
    sb_push(1, 0, "post_rst_busy");
    load({$urandom, $urandom, $urandom, $urandom});
    expand_check();
    check_all("post_rst_keys");

    for (int r = 0; r < 4; r++) begin
      load({$urandom, $urandom, $urandom, $urandom});
      expand_check();
      rand_reads(12);
    end

    step();
    @(negedge CLK);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
